// File: rtl/interrupt_sequencer_pkg.sv
// Shared types, counter width and parameter-legality limits for the interrupt sequencer.
// Used by the interface, the irq synchroniser and the sequencer top.
package interrupt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

  localparam int CNT_W = 4;

  localparam int SYNC_STAGES_MIN  = 2;
  localparam int SYNC_STAGES_MAX  = 4;
  localparam int PULSE_CYCLES_MIN = 1;
  localparam int PULSE_CYCLES_MAX = 15;
  localparam int MAX_PENDING_MIN  = 1;
  localparam int MAX_PENDING_MAX  = 15;

  // Out-of-range parameters are pulled back into the legal window.
  function automatic int clamp_param(input int val, input int lo, input int hi);
    int res;
    if (val < lo) begin
      res = lo;
    end else if (val > hi) begin
      res = hi;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Request/delivery bundle between the interrupt source, the processor and the sequencer.
// INTERRUPT_SEQ_MASK_EN adds the irq_mask input.
interface interrupt_sequencer_if;
  import interrupt_pkg::*;

  logic             irq_in;
  logic             pipe_busy;
  logic             rti_done;
`ifdef INTERRUPT_SEQ_MASK_EN
  logic             irq_mask;
`endif
  logic             interrupt_signal;
  logic             in_service;
  logic [CNT_W-1:0] pending_count;
  logic             overflow;

  modport master (
`ifdef INTERRUPT_SEQ_MASK_EN
    output irq_mask,
`endif
    output irq_in,
    output pipe_busy,
    output rti_done,
    input  interrupt_signal,
    input  in_service,
    input  pending_count,
    input  overflow
  );

  modport slave (
`ifdef INTERRUPT_SEQ_MASK_EN
    input  irq_mask,
`endif
    input  irq_in,
    input  pipe_busy,
    input  rti_done,
    output interrupt_signal,
    output in_service,
    output pending_count,
    output overflow
  );

endinterface

// File: rtl/interrupt_sequencer_sync.sv
// Synchroniser chain for the asynchronous irq_in plus a registered rising-edge detector.
// irq_event is a one-cycle pulse SYNC_STAGES+1 cycles after irq_in rises.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  output logic irq_event
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;
  logic                   event_q;
  logic                   event_d;

  // Shift the raw request in and compare the last stage against its delayed copy.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], irq_in};
    prev_d  = sync_q[SYNC_STAGES-1];
    event_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Synchroniser, edge and event registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      prev_q  <= 1'b0;
      event_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      event_q <= event_d;
    end
  end

  assign irq_event = event_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: counts synchronised requests and delivers fixed-width pulses to the
// processor, one at a time, gated by pipe_busy (and irq_mask when INTERRUPT_SEQ_MASK_EN is defined).
module interrupt_sequencer
  import interrupt_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_CYCLES = 2,
  parameter int MAX_PENDING  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_sequencer_if.slave  bus
);

  localparam int SYNC_EFF  = clamp_param(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  localparam int PULSE_EFF = clamp_param(PULSE_CYCLES, PULSE_CYCLES_MIN, PULSE_CYCLES_MAX);
  localparam int MAX_EFF   = clamp_param(MAX_PENDING, MAX_PENDING_MIN, MAX_PENDING_MAX);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_EFF);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  int_state_t       state_q;
  int_state_t       state_d;
  logic [CNT_W-1:0] pending_q;
  logic [CNT_W-1:0] pending_d;
  logic [CNT_W-1:0] pulse_cnt_q;
  logic [CNT_W-1:0] pulse_cnt_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             interrupt_signal_q;
  logic             interrupt_signal_d;
  logic             in_service_q;
  logic             in_service_d;

  logic             irq_event;
  logic             hold_off;
  logic             deliver;
  logic [CNT_W-1:0] post_dec;

  irq_sync_edge #(
    .SYNC_STAGES (SYNC_EFF)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (bus.irq_in),
    .irq_event (irq_event)
  );

`ifdef INTERRUPT_SEQ_MASK_EN
  assign hold_off = bus.pipe_busy | bus.irq_mask;
`else
  assign hold_off = bus.pipe_busy;
`endif

  // Next-state, pulse timing and pending-count bookkeeping.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    pending_d   = pending_q;
    overflow_d  = overflow_q;
    deliver     = 1'b0;
    post_dec    = pending_q;

    case (state_q)
      IDLE: begin
        if ((pending_q != CNT_ZERO) && !hold_off) begin
          deliver     = 1'b1;
          state_d     = PULSE;
          pulse_cnt_d = PULSE_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      PULSE: begin
        if (pulse_cnt_q == CNT_ZERO) begin
          state_d = SERVICE;
        end else begin
          pulse_cnt_d = pulse_cnt_q - CNT_ONE;
        end
      end
      SERVICE: begin
        if (bus.rti_done) begin
          state_d = IDLE;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d     = IDLE;
        pulse_cnt_d = CNT_ZERO;
      end
    endcase

    // The saturation check sees the count after this cycle's delivery.
    if (deliver) begin
      post_dec = pending_q - CNT_ONE;
    end else begin
      post_dec = pending_q;
    end

    if (irq_event) begin
      if (post_dec >= CNT_MAX) begin
        pending_d  = CNT_MAX;
        overflow_d = 1'b1;
      end else begin
        pending_d = post_dec + CNT_ONE;
      end
    end else begin
      pending_d = post_dec;
    end

    interrupt_signal_d = (state_d == PULSE);
    in_service_d       = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= IDLE;
      pending_q          <= CNT_ZERO;
      pulse_cnt_q        <= CNT_ZERO;
      overflow_q         <= 1'b0;
      interrupt_signal_q <= 1'b0;
      in_service_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      pending_q          <= pending_d;
      pulse_cnt_q        <= pulse_cnt_d;
      overflow_q         <= overflow_d;
      interrupt_signal_q <= interrupt_signal_d;
      in_service_q       <= in_service_d;
    end
  end

  assign bus.interrupt_signal = interrupt_signal_q;
  assign bus.in_service       = in_service_q;
  assign bus.pending_count    = pending_q;
  assign bus.overflow         = overflow_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: table of single-request cases plus hand-written
// saturation, coincident event/delivery and mid-pulse reset sequences; pulse starts are scoreboarded.
module tb_interrupt_sequencer;

  localparam int PULSE_CYCLES = 2;
  localparam int MAX_PENDING  = 3;

  typedef struct {
    int busy_lo;
    int busy_hi;
    bit rti_early;
    int exp_start;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc;
  int   hi_len;
  int   pulse_rises;
  bit   prev_int;
  int   exp_q[$];
  vec_t vecs[6];

  interrupt_sequencer_if bus ();

  interrupt_sequencer #(
    .SYNC_STAGES  (2),
    .PULSE_CYCLES (PULSE_CYCLES),
    .MAX_PENDING  (MAX_PENDING)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One clock; outputs sampled 1 time unit after the edge, pulse starts and widths scoreboarded.
  task automatic step();
    int e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.interrupt_signal === 1'b1 && !prev_int) begin
      pulse_rises++;
      hi_len = 1;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", cyc, -1);
      end else begin
        e = exp_q.pop_front();
        check("pulse_start", cyc, e);
      end
    end else if (bus.interrupt_signal === 1'b1) begin
      hi_len++;
    end else if (prev_int) begin
      check("pulse_width", hi_len, PULSE_CYCLES);
    end
    prev_int = (bus.interrupt_signal === 1'b1);
  endtask

  task automatic request(input bit expect_pulse);
    if (expect_pulse) exp_q.push_back(cyc + 5);
    bus.irq_in = 1'b1;
    repeat (3) step();
    bus.irq_in = 1'b0;
    repeat (3) step();
  endtask

  task automatic wait_service();
    int n;
    n = 0;
    while (!(bus.in_service === 1'b1 && bus.interrupt_signal === 1'b0) && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) check("service_timeout", 0, 1);
  endtask

  task automatic rti(input bit expect_next);
    if (expect_next) exp_q.push_back(cyc + 2);
    bus.rti_done = 1'b1;
    step();
    bus.rti_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    prev_int = 1'b0;
    hi_len = 0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    int rises0;
    int base;
    errors = 0;
    checks = 0;
    cyc = 0;
    hi_len = 0;
    pulse_rises = 0;
    prev_int = 1'b0;
    rst = 1'b0;
    bus.irq_in = 1'b0;
    bus.pipe_busy = 1'b0;
    bus.rti_done = 1'b0;
`ifdef INTERRUPT_SEQ_MASK_EN
    bus.irq_mask = 1'b0;
`endif

    vecs[0] = '{1, 0, 1'b0, 5};
    vecs[1] = '{2, 10, 1'b0, 12};
    vecs[2] = '{0, 3, 1'b0, 5};
    vecs[3] = '{4, 4, 1'b1, 6};
    vecs[4] = '{4, 6, 1'b0, 8};
    vecs[5] = '{5, 9, 1'b1, 5};

    repeat (2) @(posedge clk);
    #1;
    check("rst_interrupt_signal", int'(bus.interrupt_signal), 0);
    check("rst_in_service", int'(bus.in_service), 0);
    check("rst_pending_count", int'(bus.pending_count), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    rst = 1'b1;
    repeat (2) step();

    // Single request per vector, different pipe_busy windows.
    for (int v = 0; v < 6; v++) begin
      base = cyc;
      for (int t = 0; t <= 28; t++) begin
        if (t == 0) exp_q.push_back(base + vecs[v].exp_start);
        if (t == 4) check("vec_pending_after_event", int'(bus.pending_count), 1);
        if (t == vecs[v].exp_start) check("vec_in_service_at_pulse", int'(bus.in_service), 1);
        if (t == 25) check("vec_in_service_before_rti", int'(bus.in_service), 1);
        if (t == 26) begin
          check("vec_in_service_after_rti", int'(bus.in_service), 0);
          check("vec_pending_final", int'(bus.pending_count), 0);
          check("vec_overflow", int'(bus.overflow), 0);
        end
        bus.irq_in = (t < 3);
        bus.pipe_busy = (t >= vecs[v].busy_lo && t <= vecs[v].busy_hi);
        bus.rti_done = (t == 25) || (vecs[v].rti_early && t == vecs[v].exp_start);
        step();
      end
      bus.pipe_busy = 1'b0;
      bus.rti_done = 1'b0;
    end

    // Saturation while in service, then drain.
    request(1'b1);
    wait_service();
    repeat (5) request(1'b0);
    check("sat_pending", int'(bus.pending_count), MAX_PENDING);
    check("sat_overflow", int'(bus.overflow), 1);
    rises0 = pulse_rises;
    repeat (3) begin
      rti(1'b1);
      wait_service();
    end
    rti(1'b0);
    repeat (6) step();
    check("sat_deliveries", pulse_rises - rises0, 3);
    check("sat_pending_drained", int'(bus.pending_count), 0);
    check("sat_in_service_drained", int'(bus.in_service), 0);
    check("sat_overflow_sticky", int'(bus.overflow), 1);

    // Event coinciding with delivery at full count.
    do_reset();
    check("reset_clears_overflow", int'(bus.overflow), 0);
    request(1'b1);
    wait_service();
    repeat (3) request(1'b0);
    check("coinc_pending_before", int'(bus.pending_count), 3);
    bus.irq_in = 1'b1;
    step();
    step();
    rti(1'b1);
    bus.irq_in = 1'b0;
    step();
    check("coinc_pending_kept", int'(bus.pending_count), 3);
    check("coinc_no_overflow", int'(bus.overflow), 0);
    wait_service();
    repeat (3) begin
      rti(1'b1);
      wait_service();
    end
    rti(1'b0);
    repeat (4) step();
    check("coinc_pending_drained", int'(bus.pending_count), 0);

    // Asynchronous reset in the first pulse cycle.
    exp_q.push_back(cyc + 5);
    bus.irq_in = 1'b1;
    repeat (3) step();
    bus.irq_in = 1'b0;
    repeat (2) step();
    check("midpulse_high_before_reset", int'(bus.interrupt_signal), 1);
    rst = 1'b0;
    #1;
    check("midpulse_interrupt_dropped", int'(bus.interrupt_signal), 0);
    check("midpulse_in_service", int'(bus.in_service), 0);
    check("midpulse_pending", int'(bus.pending_count), 0);
    check("midpulse_overflow", int'(bus.overflow), 0);
    prev_int = 1'b0;
    hi_len = 0;
    repeat (2) step();
    rst = 1'b1;
    step();
    request(1'b1);
    wait_service();
    check("post_reset_in_service", int'(bus.in_service), 1);
    rti(1'b0);
    step();
    check("post_reset_returned", int'(bus.in_service), 0);

`ifdef INTERRUPT_SEQ_MASK_EN
    // Masked requests accumulate but are not delivered.
    bus.irq_mask = 1'b1;
    request(1'b0);
    request(1'b0);
    repeat (5) step();
    check("mask_pending", int'(bus.pending_count), 2);
    check("mask_no_service", int'(bus.in_service), 0);
    bus.irq_mask = 1'b0;
    exp_q.push_back(cyc + 1);
    step();
    wait_service();
    rti(1'b1);
    wait_service();
    rti(1'b0);
    repeat (3) step();
    check("mask_pending_drained", int'(bus.pending_count), 0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
